// File: rtl/dsc_dispatcher_pkg.sv
// Shared types and constants for the descriptor dispatcher.
// Holds the FSM state encoding, default widths/engine count and the
// descriptor field layout used by engines to locate the process number.
package dsc_dispatcher_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   localparam int unsigned DSC_WIDTH   = 1024;
   localparam int unsigned NUM_ENG_DEF = 4;
   localparam int unsigned CNT_W       = 32;

   // Descriptor field: process number
   localparam int unsigned PROCNUM_LSB = 992;
   localparam int unsigned PROCNUM_W   = 9;

endpackage

// File: rtl/dsc_rr_arbiter.sv
// Round-robin free-engine picker (purely combinational).
// Ports:
//   busy     : per-engine busy flags
//   rr_ptr   : engine index where the search starts
//   sel      : first non-busy engine at or above rr_ptr, wrapping
//   any_free : at least one engine is not busy
module dsc_rr_arbiter
   import dsc_dispatcher_pkg::*;
#(
   parameter int unsigned NUM_ENG = NUM_ENG_DEF,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_ENG-1:0] busy,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   sel,
   output logic               any_free
);

   int unsigned idx;

   // Walk upward from rr_ptr modulo NUM_ENG; the first free engine wins
   always_comb begin
      sel      = '0;
      any_free = 1'b0;
      idx      = 0;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= NUM_ENG) idx = idx - NUM_ENG;
         if (!any_free && !busy[idx[PTR_W-1:0]]) begin
            any_free = 1'b1;
            sel      = idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dsc_dispatcher.sv
// Descriptor dispatcher: pops descriptors from a show-ahead FIFO and hands
// each one to a free processing engine, round-robin.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable_i        : permits new dispatches
//   dsc_ready_i     : FIFO head valid
//   dsc_data_i      : descriptor at FIFO head
//   dsc_pull_o      : one-cycle FIFO pop pulse
//   eng_valid_o     : one-hot dispatch strobe
//   eng_dsc_o       : registered descriptor qualified by eng_valid_o
//   eng_done_i      : per-engine completion pulses
//   eng_busy_o      : per-engine busy flags
//   dispatch_cnt_o  : wrapping count of dispatched descriptors
//   idle_o          : nothing busy, nothing pending, FSM idle
//   err_o           : sticky, completion seen on a non-busy engine
module dsc_dispatcher #(
   parameter int unsigned NUM_ENG   = dsc_dispatcher_pkg::NUM_ENG_DEF,
   parameter int unsigned DSC_WIDTH = dsc_dispatcher_pkg::DSC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 dsc_ready_i,
   input  logic [DSC_WIDTH-1:0] dsc_data_i,
   output logic                 dsc_pull_o,
   output logic [NUM_ENG-1:0]   eng_valid_o,
   output logic [DSC_WIDTH-1:0] eng_dsc_o,
   input  logic [NUM_ENG-1:0]   eng_done_i,
   output logic [NUM_ENG-1:0]   eng_busy_o,
   output logic [31:0]          dispatch_cnt_o,
   output logic                 idle_o,
   output logic                 err_o
);
   import dsc_dispatcher_pkg::*;

   localparam int unsigned PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   state_t                 state_q, state_n;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_n, sel;
   logic                   any_free;
   logic [NUM_ENG-1:0]     busy_n, valid_n;
   logic                   pull_n, err_n;
   logic [DSC_WIDTH-1:0]   dsc_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;

   dsc_rr_arbiter #(
      .NUM_ENG (NUM_ENG),
      .PTR_W   (PTR_W)
   ) u_arb (
      .busy     (eng_busy_o),
      .rr_ptr   (rr_ptr_q),
      .sel      (sel),
      .any_free (any_free)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         eng_busy_o  <= '0;
         eng_valid_o <= '0;
         dsc_pull_o  <= 1'b0;
         eng_dsc_o   <= '0;
         cnt_q       <= '0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_n;
         rr_ptr_q    <= rr_ptr_n;
         eng_busy_o  <= busy_n;
         eng_valid_o <= valid_n;
         dsc_pull_o  <= pull_n;
         eng_dsc_o   <= dsc_n;
         cnt_q       <= cnt_n;
         err_o       <= err_n;
      end
   end

   // Next-state and output decode; arbitration uses the registered busy
   // flags, so an engine freed at an edge is only eligible one edge later
   always_comb begin
      state_n  = state_q;
      rr_ptr_n = rr_ptr_q;
      valid_n  = '0;
      pull_n   = 1'b0;
      dsc_n    = eng_dsc_o;
      cnt_n    = cnt_q;
      busy_n   = eng_busy_o & ~eng_done_i;
      err_n    = err_o | (|(eng_done_i & ~eng_busy_o));
      case (state_q)
         IDLE: begin
            if (enable_i && dsc_ready_i && any_free) begin
               state_n  = GAP;
               valid_n  = NUM_ENG'(1) << sel;
               pull_n   = 1'b1;
               busy_n   = busy_n | valid_n;
               dsc_n    = dsc_data_i;
               cnt_n    = cnt_q + CNT_W'(1);
               rr_ptr_n = (32'(sel) == NUM_ENG - 1) ? '0 : sel + PTR_W'(1);
            end
         end
         // One dead cycle lets the FIFO flags settle after the pop
         GAP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign dispatch_cnt_o = cnt_q;
   assign idle_o         = (state_q == IDLE) && !dsc_ready_i && (eng_busy_o == '0);

endmodule

// File: tb/tb_dsc_dispatcher.sv
// Self-checking bench for dsc_dispatcher with a scoreboard of expected
// dispatches and a simple show-ahead FIFO model driving the descriptor port.
module tb_dsc_dispatcher;

   localparam int unsigned NE = 4;
   localparam int unsigned DW = 1024;

   typedef struct {
      logic [NE-1:0] eng;
      logic [31:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable_i;
   logic          dsc_ready_i;
   logic [DW-1:0] dsc_data_i;
   logic          dsc_pull_o;
   logic [NE-1:0] eng_valid_o;
   logic [DW-1:0] eng_dsc_o;
   logic [NE-1:0] eng_done_i;
   logic [NE-1:0] eng_busy_o;
   logic [31:0]   dispatch_cnt_o;
   logic          idle_o;
   logic          err_o;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int          cyc    = 0;
   logic        pull_seen = 1'b0;
   logic [31:0] fifo[$];
   exp_t        sb[$];
   int          vcyc[$];
   int          c0, cd;

   dsc_dispatcher #(.NUM_ENG(NE), .DSC_WIDTH(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (enable_i),
      .dsc_ready_i    (dsc_ready_i),
      .dsc_data_i     (dsc_data_i),
      .dsc_pull_o     (dsc_pull_o),
      .eng_valid_o    (eng_valid_o),
      .eng_dsc_o      (eng_dsc_o),
      .eng_done_i     (eng_done_i),
      .eng_busy_o     (eng_busy_o),
      .dispatch_cnt_o (dispatch_cnt_o),
      .idle_o         (idle_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic refresh();
      dsc_ready_i = (fifo.size() != 0);
      if (fifo.size() != 0) dsc_data_i = {32{fifo[0]}};
      else                  dsc_data_i = '0;
   endtask

   // Compare every dispatch against the scoreboard head
   task automatic monitor();
      exp_t e;
      check("pull_vs_valid", 64'(dsc_pull_o), 64'(|eng_valid_o));
      if (eng_valid_o != '0) begin
         vcyc.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(eng_valid_o), 64'(0));
         end else begin
            e = sb.pop_front();
            check("eng_valid", 64'(eng_valid_o), 64'(e.eng));
            check("dsc_lo", 64'(eng_dsc_o[31:0]), 64'(e.data));
            check("dsc_full", 64'(eng_dsc_o === {32{e.data}}), 64'(1));
         end
      end
      pull_seen = dsc_pull_o;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      eng_done_i = '0;
      if (pull_seen && fifo.size() != 0) void'(fifo.pop_front());
      pull_seen = 1'b0;
      if (rst) fifo.delete();
      refresh();
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_only(input logic [31:0] d);
      fifo.push_back(d);
      refresh();
   endtask

   task automatic expect_dsc(input logic [31:0] d, input logic [NE-1:0] eng);
      exp_t e;
      e.eng  = eng;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic push(input logic [31:0] d, input logic [NE-1:0] eng);
      expect_dsc(d, eng);
      push_only(d);
   endtask

   initial begin
      rst        = 1'b1;
      enable_i   = 1'b0;
      eng_done_i = '0;
      refresh();
      steps(2);
      check("rst_valid", 64'(eng_valid_o), 64'(0));
      check("rst_pull",  64'(dsc_pull_o), 64'(0));
      check("rst_busy",  64'(eng_busy_o), 64'(0));
      check("rst_cnt",   64'(dispatch_cnt_o), 64'(0));
      check("rst_err",   64'(err_o), 64'(0));
      check("rst_dsc",   64'(eng_dsc_o == '0), 64'(1));
      check("rst_idle",  64'(idle_o), 64'(1));
      rst      = 1'b0;
      enable_i = 1'b1;
      step();

      // Four descriptors, all engines free: one dispatch every two cycles
      c0 = cyc;
      vcyc.delete();
      for (int i = 0; i < 4; i++) push(32'(i), NE'(1) << i);
      steps(8);
      check("burst_n", 64'(vcyc.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         if (i < vcyc.size()) check("burst_cyc", 64'(vcyc[i]), 64'(c0 + 2 * i + 1));
      check("burst_cnt",  64'(dispatch_cnt_o), 64'(4));
      check("burst_busy", 64'(eng_busy_o), 64'(4'b1111));
      check("burst_fifo", 64'(fifo.size()), 64'(0));

      // All busy: fifth descriptor waits until engine 2 completes
      push(32'd4, 4'b0100);
      steps(3);
      check("held_fifo", 64'(fifo.size()), 64'(1));
      check("held_nvld", 64'(vcyc.size()), 64'(4));
      check("held_busy", 64'(eng_busy_o), 64'(4'b1111));
      eng_done_i = 4'b0100;
      cd = cyc;
      steps(3);
      check("free_nvld", 64'(vcyc.size()), 64'(5));
      if (vcyc.size() == 5) check("free_lat", 64'(vcyc[4]), 64'(cd + 2));
      check("free_fifo", 64'(fifo.size()), 64'(0));

      // busy=1011 with pointer at 3: search wraps and lands on engine 2
      eng_done_i = 4'b0100;
      push(32'd5, 4'b0100);
      steps(3);
      check("wrap_busy", 64'(eng_busy_o), 64'(4'b1111));
      // Pointer must now be 3: with engines 0 and 3 free, engine 3 wins
      eng_done_i = 4'b1001;
      push(32'd6, 4'b1000);
      steps(3);
      check("ptr_busy", 64'(eng_busy_o), 64'(4'b1110));

      // Completion on an idle engine flags a sticky error
      check("err_pre", 64'(err_o), 64'(0));
      eng_done_i = 4'b0001;
      step();
      check("err_set",  64'(err_o), 64'(1));
      check("err_busy", 64'(eng_busy_o), 64'(4'b1110));
      steps(3);
      check("err_stick", 64'(err_o), 64'(1));

      // Enable dropped in the grant's output cycle: that dispatch completes only
      eng_done_i = 4'b1110;
      step();
      check("drain_busy", 64'(eng_busy_o), 64'(0));
      push(32'd10, 4'b0001);
      push_only(32'd11);
      push_only(32'd12);
      push_only(32'd13);
      step();
      enable_i = 1'b0;
      steps(6);
      check("dis_fifo", 64'(fifo.size()), 64'(3));
      check("dis_cnt",  64'(dispatch_cnt_o), 64'(8));
      check("dis_busy", 64'(eng_busy_o), 64'(4'b0001));

      // Reset while in GAP after a grant
      expect_dsc(32'd11, 4'b0010);
      enable_i = 1'b1;
      step();
      rst = 1'b1;
      step();
      check("mid_valid", 64'(eng_valid_o), 64'(0));
      check("mid_pull",  64'(dsc_pull_o), 64'(0));
      check("mid_busy",  64'(eng_busy_o), 64'(0));
      check("mid_cnt",   64'(dispatch_cnt_o), 64'(0));
      check("mid_err",   64'(err_o), 64'(0));
      check("mid_dsc",   64'(eng_dsc_o == '0), 64'(1));
      check("mid_idle",  64'(idle_o), 64'(1));
      rst = 1'b0;
      step();

      // Counter wraps from all-ones to zero on a grant
      force dut.cnt_q = 32'hFFFF_FFFF;
      step();
      release dut.cnt_q;
      check("wrap_pre", 64'(dispatch_cnt_o), 64'h0000_0000_FFFF_FFFF);
      push(32'h55, 4'b0001);
      steps(3);
      check("wrap_cnt", 64'(dispatch_cnt_o), 64'(0));
      check("sb_empty", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dsc_dispatcher.md
DSC_DISPATCHER -- requirements
Module: dsc_dispatcher

Interface
REQ-001 SHALL have parameter NUM_ENG, default 4, number of processing engines served (2..8).
REQ-002 SHALL have parameter DSC_WIDTH, default 1024, descriptor width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable_i  input  1  permits new dispatches when high.
REQ-006 SHALL have port dsc_ready_i  input  1  descriptor FIFO non-empty; head valid (show-ahead).
REQ-007 SHALL have port dsc_data_i  input  DSC_WIDTH  descriptor at FIFO head.
REQ-008 SHALL have port dsc_pull_o  output  1  one-cycle pulse that pops the FIFO head.
REQ-009 SHALL have port eng_valid_o  output  NUM_ENG  one-hot, one-cycle dispatch strobe.
REQ-010 SHALL have port eng_dsc_o  output  DSC_WIDTH  registered descriptor, qualified by eng_valid_o.
REQ-011 SHALL have port eng_done_i  input  NUM_ENG  per-engine completion pulses.
REQ-012 SHALL have port eng_busy_o  output  NUM_ENG  per-engine busy flags.
REQ-013 SHALL have port dispatch_cnt_o  output  32  number of descriptors dispatched.
REQ-014 SHALL have port idle_o  output  1  high when no engine is busy, dsc_ready_i is low and the FSM is in IDLE.
REQ-015 SHALL have port err_o  output  1  sticky: eng_done_i seen on an engine that is not busy.

Function
REQ-016 SHALL implement FSM states IDLE and GAP.
REQ-017 In IDLE, a grant SHALL occur when enable_i, dsc_ready_i and at least one ~eng_busy bit are all high at the same edge.
REQ-018 On a grant at edge T, the next state SHALL be GAP. At T+1: eng_dsc_o = dsc_data_i as sampled at T, eng_valid_o = onehot(sel), dsc_pull_o = 1, eng_busy_o[sel] = 1.
REQ-019 GAP SHALL last exactly one cycle and then return to IDLE, so FIFO flags refresh after the pop. Peak throughput is one descriptor per 2 cycles.
REQ-020 sel SHALL be the first non-busy engine at or above rr_ptr, searching upward and wrapping modulo NUM_ENG.
REQ-021 On a grant, rr_ptr SHALL be set to (sel+1) mod NUM_ENG. With no grant, rr_ptr SHALL hold.
REQ-022 eng_done_i[k] SHALL clear busy[k] at the next edge. An engine freed at edge T SHALL be eligible for grant at edge T+1, not at edge T.
REQ-023 Done on engine j and a grant to engine k≠j at the same edge SHALL both take effect.
REQ-024 eng_done_i[k] while busy[k]=0 SHALL be ignored for busy and SHALL set err_o.
REQ-025 Deasserting enable_i SHALL block new grants only. Any grant already taken SHALL complete its pull and GAP.
REQ-026 dispatch_cnt_o SHALL increment by 1 per grant and wrap from 0xFFFFFFFF to 0.
REQ-027 With all engines busy, the block SHALL hold the descriptor in the FIFO: dsc_pull_o=0, no state change.
REQ-028 dsc_pull_o and eng_valid_o SHALL never assert outside the cycle after a grant.

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE, and rr_ptr, eng_busy_o, eng_valid_o, dsc_pull_o, dispatch_cnt_o and err_o SHALL all be 0. eng_dsc_o SHALL be 0.
REQ-030 Reset mid-operation SHALL discard any in-flight grant. A descriptor already pulled is lost. Upstream and engines SHALL be reset together with this block.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, GAP), DSC_WIDTH, NUM_ENG default, and descriptor field constants PROCNUM_LSB=992, PROCNUM_W=9.
REQ-032 The combinational round-robin free-engine picker SHALL be a sub-module named dsc_rr_arbiter with inputs busy and rr_ptr and outputs sel and any_free.

Verification
REQ-033 Reset, then push 4 descriptors with data=i, all engines free -> eng_valid_o = 0001, 0010, 0100, 1000 on cycles 1, 3, 5, 7 after dsc_ready_i rises; dispatch_cnt_o=4.
REQ-034 All 4 engines busy, a 5th descriptor ready, eng_done_i=0100 pulsed -> the 5th goes to engine 2 exactly 2 cycles after the done pulse; FIFO never popped before that.
REQ-035 busy=1011, rr_ptr=3 -> sel=2 (wrap search); rr_ptr becomes 3.
REQ-036 enable_i dropped the same cycle as a grant -> that dispatch and pull complete; no further eng_valid_o while enable_i=0 with 3 descriptors queued.
REQ-037 eng_done_i=0001 while engine 0 is idle -> err_o=1 and stays 1 until rst; busy unchanged.
REQ-038 rst asserted in GAP after a grant -> next cycle all outputs 0 and FSM in IDLE; dispatch_cnt_o preset to 0xFFFFFFFF then one grant -> dispatch_cnt_o=0.
